// File: rtl/blockade_audio_pkg.sv
// Shared constants, FSM state type and saturation helper for the audio-path low-pass filter.
package blockade_audio_pkg;

  localparam int LPF_FRAC = 15;

  localparam logic [1:0] SEL_A2 = 2'd0;
  localparam logic [1:0] SEL_B1 = 2'd1;
  localparam logic [1:0] SEL_B2 = 2'd2;

  // Default section: fc ~723 Hz at div=256, DC gain of one.
  localparam int DEF_A2 = -32312;
  localparam int DEF_B1 = 228;
  localparam int DEF_B2 = 228;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} lpf_state_t;

  function automatic logic signed [63:0] sat_s64(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/blockade_iir_mac.sv
// Combinational first-order section: y = sat((B1*x + B2*x1 - A2*y1) >>> FRAC).
module blockade_iir_mac
  import blockade_audio_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CW   = 18,
  parameter int FRAC = LPF_FRAC
) (
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] x1,
  input  logic signed [DW-1:0] y1,
  input  logic signed [CW-1:0] b1,
  input  logic signed [CW-1:0] b2,
  input  logic signed [CW-1:0] a2,
  output logic signed [DW-1:0] y
);

  localparam int PW = DW + CW;
  localparam int AW = DW + CW + 2;

  logic signed [PW-1:0] p_b1, p_b2, p_a2;
  logic signed [AW-1:0] acc, shifted;

  // Two guard bits keep the three-term sum exact; the shift floors toward minus infinity.
  always_comb begin
    p_b1    = PW'(b1) * PW'(x);
    p_b2    = PW'(b2) * PW'(x1);
    p_a2    = PW'(a2) * PW'(y1);
    acc     = AW'(p_b1) + AW'(p_b2) - AW'(p_a2);
    shifted = acc >>> FRAC;
    y       = DW'(sat_s64(64'(shifted), DW));
  end

endmodule

// File: rtl/blockade_lpf_mc.sv
// Multi-channel cascaded first-order low-pass filter sharing one MAC, paced by a sample divider.
module blockade_lpf_mc
  import blockade_audio_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int STAGES   = 2,
  parameter int DW       = 16,
  parameter int CW       = 18,
  parameter int DIV_W    = 10,
  parameter int FRAC     = LPF_FRAC,
  parameter int SW       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DIV_W-1:0]       div,
  input  logic                   coef_we,
  input  logic [SW-1:0]          coef_stage,
  input  logic [1:0]             coef_sel,
  input  logic signed [CW-1:0]   coef_data,
  input  logic                   bypass,
  input  logic [CHANNELS*DW-1:0] in,
  output logic [CHANNELS*DW-1:0] out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  lpf_state_t state, state_nx;

  logic [DIV_W-1:0] cnt, period, lim;
  logic tick, start, last, byp;
  logic [CHW-1:0] ch;
  logic [SW-1:0] st;

  logic signed [CW-1:0] a2_sh [STAGES], b1_sh [STAGES], b2_sh [STAGES];
  logic signed [CW-1:0] a2_ac [STAGES], b1_ac [STAGES], b2_ac [STAGES];
  logic signed [DW-1:0] in_lat [CHANNELS];
  logic signed [DW-1:0] res [CHANNELS];
  logic signed [DW-1:0] x1_m [CHANNELS][STAGES];
  logic signed [DW-1:0] y1_m [CHANNELS][STAGES];
  logic signed [DW-1:0] prev_y, cur_x, y;

  // Period is reloaded on every wrap; its reset value of 0 makes the first tick land right after reset.
  assign lim  = (period == '0) ? DIV_W'(1) : period;
  assign tick = (cnt == lim - DIV_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      period <= '0;
    end else if (tick) begin
      cnt    <= '0;
      period <= div;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // DONE can accept a tick directly, so only a tick landing in CALC is an overrun.
  assign start = tick && (state != ST_CALC);
  assign last  = (ch == CHW'(CHANNELS - 1)) && (st == SW'(STAGES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (tick && (state == ST_CALC)) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_CALC;
      ST_CALC: begin
        busy = 1'b1;
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        state_nx  = start ? ST_CALC : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) begin
        a2_sh[s] <= CW'(DEF_A2);
        b1_sh[s] <= CW'(DEF_B1);
        b2_sh[s] <= CW'(DEF_B2);
        a2_ac[s] <= CW'(DEF_A2);
        b1_ac[s] <= CW'(DEF_B1);
        b2_ac[s] <= CW'(DEF_B2);
      end
    end else begin
      if (coef_we && (int'(coef_stage) < STAGES)) begin
        case (coef_sel)
          SEL_A2:  a2_sh[coef_stage] <= coef_data;
          SEL_B1:  b1_sh[coef_stage] <= coef_data;
          SEL_B2:  b2_sh[coef_stage] <= coef_data;
          default: ;
        endcase
      end
      if (start) begin
        a2_ac <= a2_sh;
        b1_ac <= b1_sh;
        b2_ac <= b2_sh;
      end
    end
  end

  assign cur_x = (st == '0) ? in_lat[ch] : prev_y;

  blockade_iir_mac #(
    .DW   (DW),
    .CW   (CW),
    .FRAC (FRAC)
  ) u_mac (
    .x  (cur_x),
    .x1 (x1_m[ch][st]),
    .y1 (y1_m[ch][st]),
    .b1 (b1_ac[st]),
    .b2 (b2_ac[st]),
    .a2 (a2_ac[st]),
    .y  (y)
  );

  // Stage-inner walk; out is written on the edge into DONE so it changes together with out_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out    <= '0;
      prev_y <= '0;
      byp    <= 1'b0;
      ch     <= '0;
      st     <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        in_lat[c] <= '0;
        res[c]    <= '0;
        for (int s = 0; s < STAGES; s++) begin
          x1_m[c][s] <= '0;
          y1_m[c][s] <= '0;
        end
      end
    end else if (start) begin
      byp <= bypass;
      ch  <= '0;
      st  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        in_lat[c] <= in[c*DW +: DW];
        if (bypass) begin
          for (int s = 0; s < STAGES; s++) begin
            x1_m[c][s] <= '0;
            y1_m[c][s] <= '0;
          end
        end
      end
    end else if (state == ST_CALC) begin
      prev_y <= y;
      if (!byp) begin
        x1_m[ch][st] <= cur_x;
        y1_m[ch][st] <= y;
      end
      if (st == SW'(STAGES - 1)) begin
        res[ch] <= y;
        st      <= '0;
        ch      <= ch + 1'b1;
      end else begin
        st <= st + 1'b1;
      end
      if (last) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (byp) out[c*DW +: DW] <= in_lat[c];
          else if (c == int'(ch)) out[c*DW +: DW] <= y;
          else out[c*DW +: DW] <= res[c];
        end
      end
    end
  end

endmodule
